// File: rtl/lab2_req_scheduler_pkg.sv
// Shared types and constants for the lab2 round-robin request scheduler.
package lab2_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  localparam int N_REQ_DEF   = 8;
  localparam int TIMEOUT_DEF = 12;
  localparam int CNT_W       = 4;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lab2_req_scheduler_if.sv
// Request/grant bundle between the requester pins and the scheduler.
interface lab2_req_scheduler_if
  import lab2_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ)
);
  logic             ena;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_valid;
  logic             start;
  logic             busy;
  logic             timeout_err;

  modport master (
    output ena, req, done,
    input  grant, grant_idx, grant_valid, start, busy, timeout_err
  );

  modport slave (
    input  ena, req, done,
    output grant, grant_idx, grant_valid, start, busy, timeout_err
  );
endinterface

// File: rtl/lab2_rr_pick.sv
// Combinational rotate-priority encoder: first set req bit at or above ptr, wrapping.
module lab2_rr_pick
  import lab2_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any
);

  logic [IW-1:0] cand;
  logic          found;

  // N_REQ is a power of two, so the index sum wraps on its own.
  always_comb begin
    cand     = '0;
    found    = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IW'(i);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign any  = |req;
  assign pick = any ? (N_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/lab2_req_scheduler.sv
// Round-robin scheduler sharing one lab2 datapath among N_REQ requesters.
module lab2_req_scheduler
  import lab2_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                clk,
  input logic                rst,
  lab2_req_scheduler_if.slave bus
);

  localparam int IW = idx_w(N_REQ);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IW-1:0]    cur_idx_q, cur_idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             wait_expired;
  logic             start_s;
  logic             busy_s;

  lab2_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      cur_idx_q     <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      cur_idx_q     <= cur_idx_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ena && pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.done || wait_expired) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cur_idx survives the grant clear so RELEASE can still advance ptr from it.
  always_comb begin
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    cur_idx_d     = cur_idx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ena && pick_any) begin
          grant_d       = pick;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          cur_idx_d     = pick_idx;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.done || wait_expired) begin
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          timeout_err_d = !bus.done;
        end
      end
      RELEASE: ptr_d = cur_idx_q + IW'(1);
      default: ;
    endcase
  end

  always_comb begin
    start_s = 1'b0;
    busy_s  = 1'b1;
    case (state_q)
      IDLE:    busy_s  = 1'b0;
      ISSUE:   start_s = 1'b1;
      default: ;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.start       = start_s;
  assign bus.busy        = busy_s;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lab2_req_scheduler.sv
// Directed bench for lab2_req_scheduler; inputs change and outputs are sampled on the falling edge.
module tb_lab2_req_scheduler;
  import lab2_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  lab2_req_scheduler_if #(.N_REQ(8)) bus ();

  lab2_req_scheduler #(
    .N_REQ   (8),
    .TIMEOUT (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 32'(bus.grant), 0);
    check({tag, ".idx"},   32'(bus.grant_idx), 0);
    check({tag, ".valid"}, 32'(bus.grant_valid), 0);
    check({tag, ".start"}, 32'(bus.start), 0);
    check({tag, ".busy"},  32'(bus.busy), 0);
    check({tag, ".terr"},  32'(bus.timeout_err), 0);
  endtask

  // Entered on the ISSUE cycle; done is raised on the wait_n-th WAIT cycle; returns on the IDLE cycle.
  task automatic serve(input string tag, input int exp_idx, input int wait_n);
    check({tag, ".grant"}, 32'(bus.grant), 32'(1) << exp_idx);
    check({tag, ".idx"},   32'(bus.grant_idx), 32'(exp_idx));
    check({tag, ".valid"}, 32'(bus.grant_valid), 1);
    check({tag, ".start"}, 32'(bus.start), 1);
    step();
    check({tag, ".start_off"}, 32'(bus.start), 0);
    repeat (wait_n - 1) step();
    check({tag, ".held"}, 32'(bus.grant), 32'(1) << exp_idx);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check({tag, ".rel_grant"}, 32'(bus.grant), 0);
    check({tag, ".rel_busy"},  32'(bus.busy), 1);
    check({tag, ".rel_terr"},  32'(bus.timeout_err), 0);
    step();
    check({tag, ".idle_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    rst      = 1'b1;
    bus.ena  = 1'b1;
    bus.req  = 8'hFF;
    bus.done = 1'b0;

    step();
    check_idle("rst1");
    step();
    check_idle("rst2");
    rst = 1'b0;
    step();
    check("first.grant", 32'(bus.grant), 32'h01);
    check("first.idx",   32'(bus.grant_idx), 0);
    check("first.start", 32'(bus.start), 1);
    bus.req = 8'h00;
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    check("first.idle_busy", 32'(bus.busy), 0);

    // Single request dropped while granted; ptr is 1 here.
    bus.req = 8'h04;
    step();
    bus.req = 8'h00;
    serve("single", 2, 3);

    // Reset to ptr 0 then rotate through every requester.
    rst     = 1'b1;
    bus.req = 8'hFF;
    step();
    check_idle("rst3");
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      serve($sformatf("rot%0d", k), k, 1);
    end
    bus.req = 8'h81;
    step();
    serve("wrap0", 0, 1);
    step();
    serve("wrap7", 7, 1);

    // Timeout on requester 1 with done never asserted.
    bus.req = 8'h02;
    step();
    check("to.idx", 32'(bus.grant_idx), 1);
    bus.req = 8'h00;
    repeat (12) step();
    check("to.wait12_grant", 32'(bus.grant), 32'h02);
    check("to.wait12_terr",  32'(bus.timeout_err), 0);
    step();
    check("to.rel_terr",  32'(bus.timeout_err), 1);
    check("to.rel_grant", 32'(bus.grant), 0);
    check("to.rel_busy",  32'(bus.busy), 1);
    step();
    check("to.idle_terr", 32'(bus.timeout_err), 0);
    check("to.idle_busy", 32'(bus.busy), 0);
    bus.req = 8'h06;
    step();
    bus.req = 8'h00;
    serve("to_done_wins", 2, 12);

    // Enable low blocks new grants; dropping it mid-grant does not abort.
    bus.ena = 1'b0;
    bus.req = 8'h10;
    repeat (3) begin
      step();
      check("ena0.busy",  32'(bus.busy), 0);
      check("ena0.grant", 32'(bus.grant), 0);
    end
    bus.ena = 1'b1;
    step();
    bus.ena = 1'b0;
    serve("ena_drop", 4, 3);
    step();
    check("ena_drop.no_regrant", 32'(bus.busy), 0);

    // Reset in the middle of WAIT.
    bus.ena = 1'b1;
    step();
    check("mid.idx", 32'(bus.grant_idx), 4);
    step();
    step();
    check("mid.wait_grant", 32'(bus.grant), 32'h10);
    rst     = 1'b1;
    bus.req = 8'h00;
    step();
    check_idle("mid_rst");
    rst = 1'b0;
    repeat (2) begin
      step();
      check("mid.no_start", 32'(bus.start), 0);
      check("mid.no_busy",  32'(bus.busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
